// File: rtl/rv_fetch_pkg.sv
// rv_fetch_pkg
// Shared types for the instruction fetch front end:
//   - align_state_e   : halfword aligner state (EMPTY, HALF, SKIP_LO)
//   - fetch_entry_t   : one decoded-queue entry {pc, instruction, is_compressed}
//   - FETCH_ENTRY_BITS: flat width of fetch_entry_t, used on module ports
//   - is_compressed() : RVC test on the low two bits of a halfword
package rv_fetch_pkg;

  typedef enum logic [1:0] {
    EMPTY   = 2'b00,
    HALF    = 2'b01,
    SKIP_LO = 2'b10
  } align_state_e;

  // pc is carried at full 32-bit width; the top trims it to the address space.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instruction;
    logic        is_compressed;
  } fetch_entry_t;

  localparam int FETCH_ENTRY_BITS = 65;

  function automatic logic is_compressed(input logic [15:0] halfword);
    return (halfword[1:0] != 2'b11);
  endfunction

endpackage

// File: rtl/rv_fetch_queue.sv
// rv_fetch_queue
// Circular FIFO between the aligner and decode. Accepts up to two entries per
// cycle (entry0 first, then entry1) and releases one per cycle.
// Ports:
//   clk, reset_n          clock, synchronous active-low reset
//   clear                 drop all stored entries; pushes in the same cycle are kept
//   push0/entry0          first entry written this cycle
//   push1/entry1          second entry (only ever asserted together with push0)
//   pop                   remove the head entry (ignored while clear is high)
//   head                  current head entry
//   occupancy             number of stored entries
module rv_fetch_queue
  import rv_fetch_pkg::*;
#(
  parameter int DEPTH_BITS = 2
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        clear,
  input  logic                        push0,
  input  logic [FETCH_ENTRY_BITS-1:0] entry0,
  input  logic                        push1,
  input  logic [FETCH_ENTRY_BITS-1:0] entry1,
  input  logic                        pop,
  output logic [FETCH_ENTRY_BITS-1:0] head,
  output logic [DEPTH_BITS:0]         occupancy
);

  localparam int DEPTH = 1 << DEPTH_BITS;

  logic [FETCH_ENTRY_BITS-1:0] mem_r [DEPTH];
  logic [DEPTH_BITS-1:0]       rd_ptr_r;
  logic [DEPTH_BITS-1:0]       wr_ptr_r;
  logic [DEPTH_BITS-1:0]       wr_ptr_plus1_s;
  logic [DEPTH_BITS:0]         count_r;
  logic [1:0]                  n_push_s;

  // Push count and the slot used by the second entry.
  always_comb begin
    n_push_s       = {1'b0, push0} + {1'b0, push1};
    wr_ptr_plus1_s = wr_ptr_r + DEPTH_BITS'(1);
  end

  // Entry storage; the two pushes land in consecutive slots.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
    end else begin
      if (push0) begin
        mem_r[wr_ptr_r] <= entry0;
      end
      if (push1) begin
        mem_r[wr_ptr_plus1_s] <= entry1;
      end
    end
  end

  // Pointer and count bookkeeping; clear keeps only this cycle's pushes.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rd_ptr_r <= '0;
      wr_ptr_r <= '0;
      count_r  <= '0;
    end else if (clear) begin
      rd_ptr_r <= wr_ptr_r;
      wr_ptr_r <= wr_ptr_r + DEPTH_BITS'(n_push_s);
      count_r  <= (DEPTH_BITS+1)'(n_push_s);
    end else begin
      rd_ptr_r <= rd_ptr_r + DEPTH_BITS'(pop);
      wr_ptr_r <= wr_ptr_r + DEPTH_BITS'(n_push_s);
      count_r  <= count_r + (DEPTH_BITS+1)'(n_push_s) - (DEPTH_BITS+1)'(pop);
    end
  end

  assign head      = mem_r[rd_ptr_r];
  assign occupancy = count_r;

endmodule

// File: rtl/rv_fetch_stream.sv
// rv_fetch_stream
// RV32 instruction fetch front end. Issues word-aligned reads on a pipelined
// bus, realigns 16/32-bit instructions and queues {pc, instruction,
// is_compressed} for decode. Redirects cancel in-flight reads via a drop count.
// Ports:
//   i_clk, i_reset_n              clock, synchronous active-low reset
//   i_trap, i_pc_trap             redirect to trap target (beats i_pc_select)
//   i_pc_select, i_pc_target      redirect to branch target
//   i_flush                       empty the queue, fetch PC unchanged
//   o_addr, o_cyc, i_ack          request address / valid / accept
//   i_rvalid, i_rdata             in-order read responses
//   i_stall                       decode not consuming
//   o_ready, o_pc, o_instruction,
//   o_is_compressed               queue head (zero when empty)
module rv_fetch_stream
  import rv_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_ADDR       = 32'h0000_0000,
  parameter int          IADDR_SPACE_BITS = 16,
  parameter int          QUEUE_DEPTH_BITS = 2,
  parameter int          MAX_OUTSTANDING  = 2,
  parameter bit          EXTENSION_C      = 1'b1
) (
  input  logic                        i_clk,
  input  logic                        i_reset_n,
  input  logic                        i_trap,
  input  logic [IADDR_SPACE_BITS-1:0] i_pc_trap,
  input  logic                        i_pc_select,
  input  logic [IADDR_SPACE_BITS-1:0] i_pc_target,
  input  logic                        i_flush,
  output logic [IADDR_SPACE_BITS-1:0] o_addr,
  output logic                        o_cyc,
  input  logic                        i_ack,
  input  logic                        i_rvalid,
  input  logic [31:0]                 i_rdata,
  input  logic                        i_stall,
  output logic                        o_ready,
  output logic [IADDR_SPACE_BITS-1:0] o_pc,
  output logic [31:0]                 o_instruction,
  output logic                        o_is_compressed
);

  localparam int              AW          = IADDR_SPACE_BITS;
  localparam logic [AW-1:0]   PC_HALF     = AW'(2);
  localparam logic [AW-1:0]   PC_WORD     = AW'(4);
  localparam logic [AW-1:0]   RESET_WORD  = {RESET_ADDR[AW-1:2], 2'b00};
  localparam logic [8:0]      QUEUE_SLOTS = 9'(1 << QUEUE_DEPTH_BITS);
  localparam logic [2:0]      MAX_OUT     = 3'(MAX_OUTSTANDING);

  logic                      redirect_s;
  logic [AW-1:0]             target_s;
  logic [AW-1:0]             pc_r;
  logic [AW-1:0]             resp_pc_r;
  logic [AW-1:0]             resp_pc_hi_s;
  logic [2:0]                outstanding_r;
  logic [2:0]                drop_r;
  logic                      rvalid_live_s;
  logic                      word_use_s;
  logic                      accept_s;
  logic [8:0]                demand_s;
  logic                      pop_s;
  logic                      clear_s;

  align_state_e              align_r;
  align_state_e              align_next_s;
  logic [15:0]               held_r;
  logic [15:0]               held_next_s;
  logic [AW-1:0]             held_pc_r;
  logic [AW-1:0]             held_pc_next_s;
  logic [15:0]               lo_s;
  logic [15:0]               hi_s;

  logic                      push0_s;
  logic                      push1_s;
  fetch_entry_t              entry0_s;
  fetch_entry_t              entry1_s;
  fetch_entry_t              head_s;
  logic [FETCH_ENTRY_BITS-1:0] head_bits_s;
  logic [QUEUE_DEPTH_BITS:0] occupancy_s;
  logic                      unused_s;

  // Redirect target selection: trap beats branch.
  always_comb begin
    redirect_s = i_trap | i_pc_select;
    if (i_trap) begin
      target_s = i_pc_trap;
    end else begin
      target_s = i_pc_target;
    end
  end

  // Request credit: every in-flight word may still produce two queue entries.
  always_comb begin
    demand_s = 9'(occupancy_s) + {5'd0, outstanding_r, 1'b0} + 9'd2;
    o_cyc    = i_reset_n & ~redirect_s & (demand_s <= QUEUE_SLOTS)
               & (outstanding_r < MAX_OUT);
    accept_s = o_cyc & i_ack;
    o_addr   = pc_r;
  end

  // A response only counts when a read is owed; data during the drop phase
  // or in a redirect cycle belongs to the abandoned stream.
  always_comb begin
    rvalid_live_s = i_rvalid & (outstanding_r != 3'd0);
    word_use_s    = rvalid_live_s & (drop_r == 3'd0) & ~redirect_s;
    lo_s          = i_rdata[15:0];
    hi_s          = i_rdata[31:16];
    resp_pc_hi_s  = resp_pc_r + PC_HALF;
  end

  // Fetch address, response address, outstanding and drop counters.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      pc_r          <= RESET_WORD;
      resp_pc_r     <= RESET_WORD;
      outstanding_r <= 3'd0;
      drop_r        <= 3'd0;
    end else begin
      case ({accept_s, rvalid_live_s})
        2'b10:   outstanding_r <= outstanding_r + 3'd1;
        2'b01:   outstanding_r <= outstanding_r - 3'd1;
        default: outstanding_r <= outstanding_r;
      endcase
      if (redirect_s) begin
        pc_r      <= {target_s[AW-1:2], 2'b00};
        resp_pc_r <= {target_s[AW-1:2], 2'b00};
        drop_r    <= outstanding_r - {2'b00, rvalid_live_s};
      end else begin
        if (accept_s) begin
          pc_r <= pc_r + PC_WORD;
        end
        if (rvalid_live_s && (drop_r != 3'd0)) begin
          drop_r <= drop_r - 3'd1;
        end
        if (word_use_s) begin
          resp_pc_r <= resp_pc_r + PC_WORD;
        end
      end
    end
  end

  // Aligner: splits each live word into zero, one or two queue pushes.
  always_comb begin
    push0_s        = 1'b0;
    push1_s        = 1'b0;
    entry0_s       = '0;
    entry1_s       = '0;
    align_next_s   = align_r;
    held_next_s    = held_r;
    held_pc_next_s = held_pc_r;
    if (redirect_s) begin
      if (EXTENSION_C && target_s[1]) begin
        align_next_s = SKIP_LO;
      end else begin
        align_next_s = EMPTY;
      end
    end else if (word_use_s) begin
      if (!EXTENSION_C) begin
        push0_s                = 1'b1;
        entry0_s.pc            = 32'(resp_pc_r);
        entry0_s.instruction   = i_rdata;
        entry0_s.is_compressed = 1'b0;
        align_next_s           = EMPTY;
      end else begin
        case (align_r)
          EMPTY: begin
            if (is_compressed(lo_s)) begin
              push0_s                = 1'b1;
              entry0_s.pc            = 32'(resp_pc_r);
              entry0_s.instruction   = {16'h0000, lo_s};
              entry0_s.is_compressed = 1'b1;
              if (is_compressed(hi_s)) begin
                push1_s                = 1'b1;
                entry1_s.pc            = 32'(resp_pc_hi_s);
                entry1_s.instruction   = {16'h0000, hi_s};
                entry1_s.is_compressed = 1'b1;
                align_next_s           = EMPTY;
              end else begin
                held_next_s    = hi_s;
                held_pc_next_s = resp_pc_hi_s;
                align_next_s   = HALF;
              end
            end else begin
              push0_s                = 1'b1;
              entry0_s.pc            = 32'(resp_pc_r);
              entry0_s.instruction   = i_rdata;
              entry0_s.is_compressed = 1'b0;
              align_next_s           = EMPTY;
            end
          end
          SKIP_LO: begin
            if (is_compressed(hi_s)) begin
              push0_s                = 1'b1;
              entry0_s.pc            = 32'(resp_pc_hi_s);
              entry0_s.instruction   = {16'h0000, hi_s};
              entry0_s.is_compressed = 1'b1;
              align_next_s           = EMPTY;
            end else begin
              held_next_s    = hi_s;
              held_pc_next_s = resp_pc_hi_s;
              align_next_s   = HALF;
            end
          end
          HALF: begin
            // Held upper-half start completes with this word's low half.
            push0_s                = 1'b1;
            entry0_s.pc            = 32'(held_pc_r);
            entry0_s.instruction   = {lo_s, held_r};
            entry0_s.is_compressed = 1'b0;
            if (is_compressed(hi_s)) begin
              push1_s                = 1'b1;
              entry1_s.pc            = 32'(resp_pc_hi_s);
              entry1_s.instruction   = {16'h0000, hi_s};
              entry1_s.is_compressed = 1'b1;
              align_next_s           = EMPTY;
            end else begin
              held_next_s    = hi_s;
              held_pc_next_s = resp_pc_hi_s;
              align_next_s   = HALF;
            end
          end
          default: begin
            align_next_s = EMPTY;
          end
        endcase
      end
    end else begin
      align_next_s = align_r;
    end
  end

  // Aligner state and held halfword registers.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      align_r   <= EMPTY;
      held_r    <= 16'h0000;
      held_pc_r <= '0;
    end else begin
      align_r   <= align_next_s;
      held_r    <= held_next_s;
      held_pc_r <= held_pc_next_s;
    end
  end

  // Queue control: a redirect or flush drops stored entries.
  always_comb begin
    clear_s = redirect_s | i_flush;
    pop_s   = o_ready & ~i_stall & ~i_flush;
  end

  rv_fetch_queue #(
    .DEPTH_BITS (QUEUE_DEPTH_BITS)
  ) u_queue (
    .clk       (i_clk),
    .reset_n   (i_reset_n),
    .clear     (clear_s),
    .push0     (push0_s),
    .entry0    (entry0_s),
    .push1     (push1_s),
    .entry1    (entry1_s),
    .pop       (pop_s),
    .head      (head_bits_s),
    .occupancy (occupancy_s)
  );

  assign head_s   = fetch_entry_t'(head_bits_s);
  assign unused_s = ^{head_s.pc[31:AW], target_s[0]};

  // Head presentation; zeros while the queue is empty.
  always_comb begin
    o_ready = (occupancy_s != '0);
    if (o_ready) begin
      o_pc            = head_s.pc[AW-1:0];
      o_instruction   = head_s.instruction;
      o_is_compressed = head_s.is_compressed;
    end else begin
      o_pc            = '0;
      o_instruction   = 32'h0000_0000;
      o_is_compressed = 1'b0;
    end
  end

endmodule
